// File: rtl/uart_frame_bist.sv
// UART loopback self-test: sends a burst of frames on tx_out_o and scores the frames returned on rx_in_i.
// Latency: rx_in_i crosses a 2-flop synchronizer; each received frame is scored one cycle after its first stop-bit sample.
// Backpressure: at most FIFO_DEPTH frames are in flight; TX holds the line idle while the expected-data FIFO is full.
//
// Ports:
//   clk_i, rst_i          UART clock, synchronous active-high reset
//   start_i               one-cycle run request, ignored while busy_o
//   par_en_i, par_typ_i   parity present / odd parity
//   stop2_i               two stop bits
//   prescale_i            clocks per bit, values below 4 run as 4
//   seed_i, frame_count_i first payload, number of frames
//   rx_in_i / tx_out_o    returned / generated serial lines, idle high
//   busy_o, done_o        run in progress, one-cycle end-of-run pulse
//   pass_cnt_o, err_cnt_o saturating good / bad-or-lost frame counts
//   last_err_o            expected payload of the most recent error
module uart_frame_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    input  logic                  stop2_i,
    input  logic [5:0]            prescale_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [CNT_WIDTH-1:0]  frame_count_i,
    input  logic                  rx_in_i,
    output logic                  tx_out_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  pass_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [DATA_WIDTH-1:0] last_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT * 64 + 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_CHECK} rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic                  busy_q, done_q, par_en_q, par_typ_q, stop2_q;
    logic [5:0]            psc_q;
    logic [DATA_WIDTH-1:0] pay_q, last_q, tx_dat_q, rx_dat_q;
    logic [CNT_WIDTH-1:0]  left_q, pass_q, err_q;
    logic [5:0]            tx_cnt_q, rx_cnt_q;
    logic [BW-1:0]         tx_bit_q, rx_bit_q;
    logic                  rx_s1_q, rx_s2_q, rx_prev_q, rx_par_q, rx_stop_q, smp_a_q, smp_b_q;
    logic [DATA_WIDTH-1:0] fifo_q [2**AW];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           fcnt_q;
    logic [TW-1:0]         to_cnt_q;

    logic fifo_full, fifo_empty, push, pop, start_ok, run_end;
    logic tx_bit_end, tx_last_stop, tx_go, tx_par;
    logic rx_fall, rx_mid, rx_bit_end, maj, rx_good, chk, to_run, to_hit;
    logic pass_ev, err_ev, last_upd;
    logic [5:0]            half;
    logic [TW-1:0]         to_lim;
    logic [DATA_WIDTH-1:0] head;

    assign fifo_full  = fcnt_q == (AW+1)'(FIFO_DEPTH);
    assign fifo_empty = fcnt_q == '0;
    assign head       = fifo_q[rd_ptr_q];
    assign start_ok   = start_i && !busy_q;
    assign run_end    = busy_q && left_q == '0 && fifo_empty &&
                        tx_state_q == TX_IDLE && rx_state_q == RX_IDLE;

    // TX: a frame may start straight out of its predecessor's final stop cycle,
    // so a non-stalled burst is seamless on the wire.
    assign tx_bit_end   = tx_cnt_q == psc_q - 6'd1;
    assign tx_last_stop = tx_state_q == TX_STOP && tx_bit_end && (!stop2_q || tx_bit_q[0]);
    assign tx_go        = busy_q && left_q != '0 && !fifo_full &&
                          (tx_state_q == TX_IDLE || tx_last_stop);
    assign push         = tx_go;
    assign tx_par       = par_typ_q ? ~^tx_dat_q : ^tx_dat_q;

    // RX: 3-sample majority around mid-bit; the third sample completes the vote.
    assign half       = {1'b0, psc_q[5:1]};
    assign rx_fall    = busy_q && rx_prev_q && !rx_s2_q;
    assign rx_mid     = rx_cnt_q == half + 6'd1;
    assign rx_bit_end = rx_cnt_q == psc_q - 6'd1;
    assign maj        = (smp_a_q & smp_b_q) | (smp_a_q & rx_s2_q) | (smp_b_q & rx_s2_q);
    assign chk        = rx_state_q == RX_CHECK;
    assign rx_good    = rx_dat_q == head && rx_stop_q &&
                        (!par_en_q || rx_par_q == (par_typ_q ? ~^rx_dat_q : ^rx_dat_q));

    // Lost-frame timer: runs only while something is expected and RX is idle.
    assign to_lim   = TW'(TIMEOUT) * TW'(psc_q);
    assign to_run   = busy_q && !fifo_empty && rx_state_q == RX_IDLE;
    assign to_hit   = to_run && to_cnt_q == to_lim - 1'b1;
    assign pop      = (chk && !fifo_empty) || to_hit;
    assign pass_ev  = chk && !fifo_empty && rx_good;
    assign err_ev   = (chk && !pass_ev) || to_hit;
    assign last_upd = pop && !pass_ev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (tx_go) tx_state_d = TX_START;
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_q == BW'(DATA_WIDTH-1))
                          tx_state_d = par_en_q ? TX_PAR : TX_STOP;
            TX_PAR:   if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_last_stop) tx_state_d = tx_go ? TX_START : TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
            RX_START: if (rx_mid && maj) rx_state_d = RX_IDLE;
                      else if (rx_bit_end) rx_state_d = RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit_q == BW'(DATA_WIDTH-1))
                          rx_state_d = par_en_q ? RX_PAR : RX_STOP;
            RX_PAR:   if (rx_bit_end) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_mid) rx_state_d = RX_CHECK;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_out_o = 1'b1;
        case (tx_state_q)
            TX_START: tx_out_o = 1'b0;
            TX_DATA:  tx_out_o = tx_dat_q[tx_bit_q];
            TX_PAR:   tx_out_o = tx_par;
            default:  tx_out_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= pay_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;   done_q <= 1'b0;    par_en_q <= 1'b0;  par_typ_q <= 1'b0;
            stop2_q <= 1'b0;  psc_q <= 6'd4;     pay_q <= '0;       left_q <= '0;
            pass_q <= '0;     err_q <= '0;       last_q <= '0;
            tx_cnt_q <= '0;   tx_bit_q <= '0;    tx_dat_q <= '0;
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;   rx_prev_q <= 1'b1;
            rx_cnt_q <= '0;   rx_bit_q <= '0;    rx_dat_q <= '0;
            rx_par_q <= 1'b0; rx_stop_q <= 1'b0; smp_a_q <= 1'b1;   smp_b_q <= 1'b1;
            wr_ptr_q <= '0;   rd_ptr_q <= '0;    fcnt_q <= '0;      to_cnt_q <= '0;
        end else begin
            done_q <= run_end;
            if (start_ok) begin
                busy_q    <= 1'b1;
                par_en_q  <= par_en_i;
                par_typ_q <= par_typ_i;
                stop2_q   <= stop2_i;
                psc_q     <= (prescale_i < 6'd4) ? 6'd4 : prescale_i;
                pay_q     <= seed_i;
                left_q    <= frame_count_i;
                pass_q    <= '0;
                err_q     <= '0;
                last_q    <= '0;
            end else begin
                if (run_end) busy_q <= 1'b0;
                if (pass_ev && pass_q != '1) pass_q <= pass_q + 1'b1;
                if (err_ev && err_q != '1) err_q <= err_q + 1'b1;
                if (last_upd) last_q <= head;
            end
            if (tx_go) begin
                pay_q    <= pay_q + 1'b1;
                left_q   <= left_q - 1'b1;
                tx_dat_q <= pay_q;
            end
            tx_cnt_q <= (tx_state_q == TX_IDLE || tx_bit_end) ? 6'd0 : tx_cnt_q + 6'd1;
            if (tx_state_d != tx_state_q) tx_bit_q <= '0;
            else if (tx_bit_end)          tx_bit_q <= tx_bit_q + 1'b1;

            rx_s1_q   <= rx_in_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_cnt_q == half - 6'd1) smp_a_q <= rx_s2_q;
            if (rx_cnt_q == half)        smp_b_q <= rx_s2_q;
            rx_cnt_q <= (rx_state_q == RX_IDLE || rx_state_d != rx_state_q || rx_bit_end) ?
                        6'd0 : rx_cnt_q + 6'd1;
            if (rx_state_d != rx_state_q)                rx_bit_q <= '0;
            else if (rx_state_q == RX_DATA && rx_bit_end) rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_state_q == RX_DATA && rx_mid) rx_dat_q[rx_bit_q] <= maj;
            if (rx_state_q == RX_PAR && rx_mid)  rx_par_q <= maj;
            if (rx_state_q == RX_STOP && rx_mid) rx_stop_q <= maj;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
            to_cnt_q <= (!to_run || to_hit) ? '0 : to_cnt_q + 1'b1;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_cnt_o = pass_q;
    assign err_cnt_o  = err_q;
    assign last_err_o = last_q;

endmodule
